// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store traffic,
// alternating on contention, with a handshake towards variable-latency memory and a watchdog.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_ready,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_ack,
  output logic              if_stall,
  output logic              mem_stall,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, INST, DATA, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic              last_data, last_data_nxt;  // 1: data port won the last grant
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              ram_cs_nxt, ram_we_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] ram_din_nxt, if_data_nxt, d_rdata_nxt;
  logic              if_ready_nxt, d_ready_nxt, bus_err_nxt;
  logic              d_pend, grant_data, expired;

  assign d_pend     = d_ren | d_wen;
  assign grant_data = d_pend & (~if_req | ~last_data);
  assign expired    = (cnt == CNT_LAST) & ~ram_ack;

  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = d_pend & ~d_ready;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_data <= 1'b0;
      cnt       <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      if_data   <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_data <= last_data_nxt;
      cnt       <= cnt_nxt;
      ram_cs    <= ram_cs_nxt;
      ram_we    <= ram_we_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_din   <= ram_din_nxt;
      if_data   <= if_data_nxt;
      d_rdata   <= d_rdata_nxt;
      if_ready  <= if_ready_nxt;
      d_ready   <= d_ready_nxt;
      bus_err   <= bus_err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_data)  state_nxt = DATA;
        else if (if_req) state_nxt = INST;
      end
      INST, DATA: begin
        if (ram_ack || expired) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A timed-out read returns zero; writes never touch d_rdata
  always_comb begin
    last_data_nxt = last_data;
    cnt_nxt       = cnt;
    ram_cs_nxt    = ram_cs;
    ram_we_nxt    = ram_we;
    ram_addr_nxt  = ram_addr;
    ram_din_nxt   = ram_din;
    if_data_nxt   = if_data;
    d_rdata_nxt   = d_rdata;
    if_ready_nxt  = 1'b0;
    d_ready_nxt   = 1'b0;
    bus_err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_data) begin
          ram_cs_nxt    = 1'b1;
          ram_we_nxt    = d_wen;
          ram_addr_nxt  = d_addr;
          ram_din_nxt   = d_wdata;
          cnt_nxt       = '0;
          last_data_nxt = 1'b1;
        end else if (if_req) begin
          ram_cs_nxt    = 1'b1;
          ram_we_nxt    = 1'b0;
          ram_addr_nxt  = if_addr;
          cnt_nxt       = '0;
          last_data_nxt = 1'b0;
        end
      end
      INST, DATA: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (ram_ack || expired) begin
          ram_cs_nxt  = 1'b0;
          ram_we_nxt  = 1'b0;
          bus_err_nxt = expired;
          if (state == INST) begin
            if_ready_nxt = 1'b1;
            if_data_nxt  = ram_ack ? ram_dout : '0;
          end else begin
            d_ready_nxt = 1'b1;
            if (!ram_we) d_rdata_nxt = ram_ack ? ram_dout : '0;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned T  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, d_ren = 1'b0, d_wen = 1'b0, ram_ack = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, ram_dout = '0;
  logic [DW-1:0] if_data, d_rdata, ram_din;
  logic [AW-1:0] ram_addr;
  logic          if_ready, d_ready, ram_cs, ram_we, if_stall, mem_stall, bus_err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ready(if_ready),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_ack(ram_ack),
    .if_stall(if_stall), .mem_stall(mem_stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          is_data;
    bit          ren;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_cyc;   // 0: memory never acknowledges
    logic [31:0] dout;
    int          exp_rdy;   // cycle of the ready pulse, request driven in cycle 0
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v, input int idx);
    step();
    ram_ack = 1'b0;
    if (v.is_data) begin
      d_ren = v.ren; d_wen = v.wen; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    chk($sformatf("v%0d stall c0", idx), v.is_data ? mem_stall : if_stall, 64'd1);
    for (int c = 1; c <= v.exp_rdy + 2; c++) begin
      step();
      if (c == v.exp_rdy + 1) begin
        if_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
      end
      ram_ack  = (c == v.ack_cyc);
      ram_dout = ram_ack ? v.dout : $urandom;
      #1;
      if (c < v.exp_rdy) begin
        chk($sformatf("v%0d cs c%0d", idx, c), ram_cs, 64'd1);
        chk($sformatf("v%0d addr c%0d", idx, c), ram_addr, v.addr);
        chk($sformatf("v%0d we c%0d", idx, c), ram_we, v.is_data & v.wen);
        if (v.wen) chk($sformatf("v%0d din c%0d", idx, c), ram_din, v.wdata);
        chk($sformatf("v%0d early ready c%0d", idx, c), v.is_data ? d_ready : if_ready, 64'd0);
      end else if (c == v.exp_rdy) begin
        chk($sformatf("v%0d ready", idx), v.is_data ? d_ready : if_ready, 64'd1);
        chk($sformatf("v%0d bus_err", idx), bus_err, v.exp_err);
        chk($sformatf("v%0d data", idx), v.is_data ? d_rdata : if_data, v.exp_data);
        chk($sformatf("v%0d cs off", idx), ram_cs, 64'd0);
        chk($sformatf("v%0d stall off", idx), v.is_data ? mem_stall : if_stall, 64'd0);
      end else begin
        chk($sformatf("v%0d ready after c%0d", idx, c), {d_ready, if_ready, bus_err}, 64'd0);
        chk($sformatf("v%0d cs after c%0d", idx, c), ram_cs, 64'd0);
        chk($sformatf("v%0d data held c%0d", idx, c), v.is_data ? d_rdata : if_data, v.exp_data);
      end
    end
  endtask

  // Transaction-level reference model state for the random run
  logic [31:0] mem [logic [31:0]];
  bit          m_busy, m_data, m_we, m_last_data, i_done, d_done;
  logic [31:0] m_addr, m_wdata, m_rdval, exp_if, exp_d;
  int          m_g, m_l, m_end, m_rdy;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  function automatic logic [31:0] rnd_addr();
    return 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4;
  endfunction

  task automatic new_d();
    int op;
    op      = int'($urandom_range(0, 2));
    d_ren   = (op != 1);
    d_wen   = (op != 0);
    d_addr  = rnd_addr();
    d_wdata = $urandom;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    if_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0; ram_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] seq [4];
    logic        e_cs, e_fin, e_ir, e_dr, e_err, pd;
    logic [31:0] v;

    vecs[0] = '{0, 0, 0, 32'h10, 32'h0,        1, 32'h2008_0005, 2, 32'h2008_0005, 0};
    vecs[1] = '{1, 1, 0, 32'h100, 32'h0,       2, 32'h1234_5678, 3, 32'h1234_5678, 0};
    vecs[2] = '{1, 0, 1, 32'h40, 32'hDEAD_BEEF, 3, 32'h5555_AAAA, 4, 32'h1234_5678, 0};
    vecs[3] = '{1, 1, 0, 32'h44, 32'h0,        4, 32'hCAFE_F00D, 5, 32'hCAFE_F00D, 0};
    vecs[4] = '{1, 1, 0, 32'h48, 32'h0,        6, 32'h9999_9999, 5, 32'h0,         1};
    vecs[5] = '{0, 0, 0, 32'h14, 32'h0,        0, 32'h0,         5, 32'h0,         1};
    vecs[6] = '{1, 0, 1, 32'h50, 32'h1111_2222, 0, 32'h0,        5, 32'h0,         1};
    vecs[7] = '{0, 0, 0, 32'h18, 32'h0,        1, 32'h8C22_0000, 2, 32'h8C22_0000, 0};
    vecs[8] = '{1, 1, 1, 32'h60, 32'h0BAD_F00D, 2, 32'h7777_7777, 3, 32'h0,        0};

    // Reset values
    step();
    rst = 1'b1;
    step();
    step();
    #1;
    chk("rst ram_cs", ram_cs, 64'd0);
    chk("rst ram_we", ram_we, 64'd0);
    chk("rst ram_addr", ram_addr, 64'd0);
    chk("rst ram_din", ram_din, 64'd0);
    chk("rst if_data", if_data, 64'd0);
    chk("rst d_rdata", d_rdata, 64'd0);
    chk("rst readies", {if_ready, d_ready, bus_err}, 64'd0);
    chk("rst stalls", {if_stall, mem_stall}, 64'd0);
    rst = 1'b0;

    // Contention right after reset: data first, then strict alternation
    seq[0] = 32'h100; seq[1] = 32'h4; seq[2] = 32'h100; seq[3] = 32'h4;
    step();
    if_req = 1'b1; if_addr = 32'h4; d_ren = 1'b1; d_addr = 32'h100;
    #1;
    chk("cont stalls c0", {if_stall, mem_stall}, 64'd3);
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 12) begin
        if_req = 1'b0; d_ren = 1'b0;
      end
      ram_ack  = ram_cs;
      ram_dout = 32'hA000_0000 + 32'(c);
      #1;
      chk($sformatf("cont cs c%0d", c), ram_cs, (c % 3) == 1);
      if ((c % 3) == 1) chk($sformatf("cont addr c%0d", c), ram_addr, seq[(c - 1) / 3]);
      chk($sformatf("cont d_ready c%0d", c), d_ready, (c == 2) || (c == 8));
      chk($sformatf("cont if_ready c%0d", c), if_ready, (c == 5) || (c == 11));
      if (c == 2 || c == 8) chk($sformatf("cont d_rdata c%0d", c), d_rdata, 32'hA000_0000 + 32'(c - 1));
      if (c == 5 || c == 11) chk($sformatf("cont if_data c%0d", c), if_data, 32'hA000_0000 + 32'(c - 1));
    end
    step();
    ram_ack = 1'b0;

    do_reset();
    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset in the middle of a data wait, then a late ack
    step();
    d_ren = 1'b1; d_addr = 32'h80;
    step();
    #1;
    chk("rstmid cs c1", ram_cs, 64'd1);
    chk("rstmid addr c1", ram_addr, 64'h80);
    step();
    rst = 1'b1; d_ren = 1'b0;
    #1;
    chk("rstmid cs c2", ram_cs, 64'd1);
    step();
    rst = 1'b0; ram_ack = 1'b1; ram_dout = 32'hFFFF_FFFF;
    #1;
    chk("rstmid cs c3", ram_cs, 64'd0);
    chk("rstmid flags c3", {d_ready, bus_err}, 64'd0);
    step();
    ram_ack = 1'b0; if_req = 1'b1; if_addr = 32'h200;
    #1;
    chk("rstmid flags c4", {d_ready, bus_err, ram_cs}, 64'd0);
    chk("rstmid d_rdata c4", d_rdata, 64'd0);
    chk("rstmid if_data c4", if_data, 64'd0);
    step();
    ram_ack = 1'b1; ram_dout = 32'h0123_4567;
    #1;
    chk("rstmid cs c5", ram_cs, 64'd1);
    chk("rstmid addr c5", ram_addr, 64'h200);
    step();
    ram_ack = 1'b0;
    #1;
    chk("rstmid if_ready c6", if_ready, 64'd1);
    chk("rstmid if_data c6", if_data, 64'h0123_4567);
    step();
    if_req = 1'b0;
    #1;
    chk("rstmid if_ready c7", if_ready, 64'd0);

    // Randomized traffic against the reference model
    do_reset();
    m_busy = 0; m_last_data = 0; i_done = 0; d_done = 0;
    exp_if = '0; exp_d = '0;
    for (int t = 0; t < 3000; t++) begin
      step();
      if (m_busy && t > m_rdy) begin
        m_busy = 0;
        if (m_data) d_done = d_ren | d_wen;
        else        i_done = if_req;
      end
      if (if_req) begin
        if (i_done) begin
          i_done = 0;
          if ($urandom_range(0, 1) != 0) if_addr = rnd_addr();
          else if_req = 1'b0;
        end else if (m_busy && !m_data && $urandom_range(0, 9) == 0) if_req = 1'b0;
      end else if (!(m_busy && !m_data) && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = rnd_addr();
      end
      if (d_ren | d_wen) begin
        if (d_done) begin
          d_done = 0;
          if ($urandom_range(0, 1) != 0) new_d();
          else begin d_ren = 1'b0; d_wen = 1'b0; end
        end else if (m_busy && m_data && $urandom_range(0, 9) == 0) begin
          d_ren = 1'b0; d_wen = 1'b0;
        end
      end else if (!(m_busy && m_data) && $urandom_range(0, 2) == 0) new_d();

      ram_ack = 1'b0; ram_dout = $urandom;
      if (m_busy && m_l <= int'(T) && t == m_g + m_l) begin
        ram_ack = 1'b1;
        if (m_we) mem[m_addr] = m_wdata;
        else begin
          ram_dout = mem_rd(m_addr);
          m_rdval  = ram_dout;
        end
      end else if (!(m_busy && t > m_g && t <= m_end) && $urandom_range(0, 7) == 0) ram_ack = 1'b1;
      #1;

      e_cs  = m_busy && t > m_g && t <= m_end;
      e_fin = m_busy && t == m_rdy;
      e_ir  = e_fin && !m_data;
      e_dr  = e_fin && m_data;
      e_err = e_fin && m_l > int'(T);
      if (e_fin && !m_we) begin
        v = (m_l <= int'(T)) ? m_rdval : 32'h0;
        if (m_data) exp_d = v;
        else        exp_if = v;
      end
      chk($sformatf("rnd ram_cs t%0d", t), ram_cs, e_cs);
      chk($sformatf("rnd if_ready t%0d", t), if_ready, e_ir);
      chk($sformatf("rnd d_ready t%0d", t), d_ready, e_dr);
      chk($sformatf("rnd bus_err t%0d", t), bus_err, e_err);
      chk($sformatf("rnd if_data t%0d", t), if_data, exp_if);
      chk($sformatf("rnd d_rdata t%0d", t), d_rdata, exp_d);
      chk($sformatf("rnd if_stall t%0d", t), if_stall, if_req & ~e_ir);
      chk($sformatf("rnd mem_stall t%0d", t), mem_stall, (d_ren | d_wen) & ~e_dr);
      if (e_cs) begin
        chk($sformatf("rnd ram_addr t%0d", t), ram_addr, m_addr);
        chk($sformatf("rnd ram_we t%0d", t), ram_we, m_we);
        if (m_we) chk($sformatf("rnd ram_din t%0d", t), ram_din, m_wdata);
      end

      if (!m_busy) begin
        pd = d_ren | d_wen;
        if (pd && (!if_req || !m_last_data)) begin
          m_data = 1; m_we = d_wen; m_addr = d_addr; m_wdata = d_wdata;
        end else if (if_req) begin
          m_data = 0; m_we = 0; m_addr = if_addr;
        end
        if (pd || if_req) begin
          m_last_data = m_data;
          m_busy = 1;
          m_g    = t;
          m_l    = int'($urandom_range(1, 6));
          m_end  = t + ((m_l > int'(T)) ? int'(T) : m_l);
          m_rdy  = m_end + 1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
